// File: rtl/norm_shift_ctrl_pkg.sv
// Shared types and constants for the normalisation sequencer.
// Optional statistics counter is enabled by defining NORM_SHIFT_STATS_EN.
package norm_pkg;
    localparam int DATA_W = 32;
    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] ZERO_CODE = 6'd32;
    localparam int STATS_W = 16;

    typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;
endpackage

// File: rtl/norm_shift_ctrl_if.sv
// Request/result channels of the normalisation sequencer.
interface norm_shift_ctrl_if #(parameter int EXP_W = 8);
    import norm_pkg::*;

    // Both channels: a transfer happens on a rising edge where valid and ready
    // are both high; the sender holds valid and its payload until then.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_underflow;

    modport master (
        output in_valid, in_data, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_zero, out_underflow
    );

    modport slave (
        input  in_valid, in_data, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_zero, out_underflow
    );
endinterface

// File: rtl/encoder.sv
// Existing 32-to-6 one-hot encoder; an all-zero input yields 6'b100000.
module encoder (
    input  logic [31:0] onehot,
    output logic [5:0]  code
);
    always_comb begin
        code = 6'b100000;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) code = 6'(i);
        end
    end
endmodule

// File: rtl/norm_shift_ctrl_msb_onehot.sv
// Isolates the highest set bit of a 31-bit vector as a one-hot word.
module msb_onehot (
    input  logic [30:0] vec,
    output logic [30:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < 31; i++) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/norm_shift_ctrl.sv
// Multi-cycle mantissa normaliser with exponent clamp (IDLE/DETECT/SHIFT/DONE).
// Define NORM_SHIFT_STATS_EN to add the saturating op_count output.
module norm_shift_ctrl
    import norm_pkg::*;
#(
    parameter int SHIFT_STEP = 8,
    parameter int EXP_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    norm_shift_ctrl_if.slave    bus,
    output state_t              dbg_state
`ifdef NORM_SHIFT_STATS_EN
    ,
    output logic [STATS_W-1:0]  op_count
`endif
);
    localparam logic [CODE_W-1:0] STEP_C = CODE_W'(SHIFT_STEP);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [CODE_W-1:0]   rem_q, rem_d;
    logic                zero_q, zero_d;
    logic                unf_q, unf_d;

    logic [30:0]         onehot;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   s_raw, s_fin, amt;
    logic                zero_det, unf_det;

    msb_onehot u_msb (.vec(data_q[30:0]), .onehot(onehot));

    // Shifted up one place so a bit at position p encodes as p+1; 0 stays the zero code.
    encoder u_enc (.onehot({onehot, 1'b0}), .code(code));

    always_comb begin
        zero_det = !data_q[31] && (code == ZERO_CODE);
        s_raw    = '0;
        if (!data_q[31] && !zero_det) s_raw = 6'd32 - code;
        unf_det  = 32'(s_raw) > 32'(exp_q);
        s_fin    = unf_det ? CODE_W'(exp_q) : s_raw;
        amt      = (rem_q < STEP_C) ? rem_q : STEP_C;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    exp_d   = bus.in_exp;
                    rem_d   = '0;
                    zero_d  = 1'b0;
                    unf_d   = 1'b0;
                    state_d = DETECT;
                end
            end
            DETECT: begin
                zero_d = zero_det;
                unf_d  = unf_det;
                if (s_fin == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d   = s_fin;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // amt never exceeds the remaining exp budget, so exp cannot wrap.
                data_d = data_q << amt;
                exp_d  = exp_q - EXP_W'(amt);
                rem_d  = rem_q - amt;
                if (rem_q == amt) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_data      = data_q;
    assign bus.out_exp       = exp_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_underflow = unf_q;
    assign dbg_state         = state_q;

`ifdef NORM_SHIFT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (state_q == DONE && bus.out_ready && op_count != '1) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl: vector table, random ops vs. model, corner sequences.
module tb_norm_shift_ctrl;
    import norm_pkg::*;

    localparam int STEP = 8;
    localparam int EW   = 8;

    logic   clk;
    logic   rst;
    state_t dbg_state;
`ifdef NORM_SHIFT_STATS_EN
    logic [STATS_W-1:0] op_count;
`endif

    norm_shift_ctrl_if #(.EXP_W(EW)) bus ();

    norm_shift_ctrl #(.SHIFT_STEP(STEP), .EXP_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
`ifdef NORM_SHIFT_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference: leading-one position by search, clamp by exponent, plain shift.
    function automatic void model(input logic [31:0] d, input logic [EW-1:0] e,
                                  output logic [31:0] od, output logic [EW-1:0] oe,
                                  output logic oz, output logic ou, output int lat);
        int s;
        s  = 0;
        oz = (d == 32'd0);
        ou = 1'b0;
        if (d != 32'd0) begin
            int p;
            p = 31;
            while (d[p] == 1'b0) p--;
            s = 31 - p;
        end
        if (s > int'(e)) begin
            s  = int'(e);
            ou = 1'b1;
        end
        od  = d << s;
        oe  = EW'(int'(e) - s);
        lat = 2 + (s + STEP - 1) / STEP;
    endfunction

    // driver: issue one request, measure cycles until out_valid, optionally accept
    task automatic run_op(input logic [31:0] d, input logic [EW-1:0] e, input bit release_out,
                          output logic [31:0] od, output logic [EW-1:0] oe,
                          output logic oz, output logic ou, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_exp   = e;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got no out_valid within 40 cycles, expected one");
        end
        od = bus.out_data;
        oe = bus.out_exp;
        oz = bus.out_zero;
        ou = bus.out_underflow;
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("in_ready_after_release", 64'(bus.in_ready), 64'(1));
            check("out_valid_after_release", 64'(bus.out_valid), 64'(0));
        end
    endtask

    typedef struct {
        logic [31:0]   din;
        logic [EW-1:0] ein;
        logic [31:0]   dout;
        logic [EW-1:0] eout;
        logic          z;
        logic          u;
        int            lat;
    } vec_t;

    vec_t vecs[9];
    logic [41:0] exp_q[$];

    initial begin
        logic [31:0]   od, snap_d, rd;
        logic [EW-1:0] oe, snap_e, re;
        logic          oz, ou, rz, ru;
        int            lat, rlat;
        logic [41:0]   want;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{32'h0000_0001, 8'd100, 32'h8000_0000, 8'd69,  1'b0, 1'b0, 6};
        vecs[1] = '{32'h4000_0000, 8'd5,   32'h8000_0000, 8'd4,   1'b0, 1'b0, 3};
        vecs[2] = '{32'h0000_0000, 8'd7,   32'h0000_0000, 8'd7,   1'b1, 1'b0, 2};
        vecs[3] = '{32'h0000_0100, 8'd10,  32'h0004_0000, 8'd0,   1'b0, 1'b1, 4};
        vecs[4] = '{32'h8000_0000, 8'd3,   32'h8000_0000, 8'd3,   1'b0, 1'b0, 2};
        vecs[5] = '{32'h0000_0001, 8'd0,   32'h0000_0001, 8'd0,   1'b0, 1'b1, 2};
        vecs[6] = '{32'h00FF_0000, 8'd200, 32'hFF00_0000, 8'd192, 1'b0, 1'b0, 3};
        vecs[7] = '{32'h0000_0100, 8'd23,  32'h8000_0000, 8'd0,   1'b0, 1'b0, 5};
        vecs[8] = '{32'h0000_FFFF, 8'd16,  32'hFFFF_0000, 8'd0,   1'b0, 1'b0, 4};

        // reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_exp", 64'(bus.out_exp), 64'(0));
        check("rst_flags", 64'({bus.out_zero, bus.out_underflow}), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // table vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].din, vecs[i].ein, 1'b1, od, oe, oz, ou, lat);
            check($sformatf("vec%0d_data", i), 64'(od), 64'(vecs[i].dout));
            check($sformatf("vec%0d_exp", i), 64'(oe), 64'(vecs[i].eout));
            check($sformatf("vec%0d_zero", i), 64'(oz), 64'(vecs[i].z));
            check($sformatf("vec%0d_unf", i), 64'(ou), 64'(vecs[i].u));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // random requests against the model
        for (int i = 0; i < 40; i++) begin
            rd = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) rd = '0;
            re = ($urandom_range(0, 1) == 0) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 255));
            model(rd, re, od, oe, rz, ru, rlat);
            exp_q.push_back({od, oe, rz, ru});
            run_op(rd, re, 1'b1, od, oe, oz, ou, lat);
            want = exp_q.pop_front();
            check($sformatf("rand%0d_result d=%h e=%0d", i, rd, re), 64'({od, oe, oz, ou}), 64'(want));
            check($sformatf("rand%0d_lat", i), 64'(lat), 64'(rlat));
        end

        // backpressure: DONE held for 5 cycles while a second request is offered
        run_op(32'h0000_0001, 8'd100, 1'b0, snap_d, snap_e, oz, ou, lat);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_data_stable", 64'(bus.out_data), 64'(snap_d));
            check("bp_exp_stable", 64'(bus.out_exp), 64'(snap_e));
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h1234_5678;
            bus.in_exp   = 8'd50;
            @(negedge clk);
        end
        check("bp_data_final", 64'(bus.out_data), 64'(32'h8000_0000));
        check("bp_exp_final", 64'(bus.out_exp), 64'(69));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_in_ready_after", 64'(bus.in_ready), 64'(1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_ignored_no_output", 64'(bus.out_valid), 64'(0));
        end

        // asynchronous reset in the middle of shifting
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_exp   = 8'd100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_state_shift", 64'(dbg_state), 64'(SHIFT));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_out_data", 64'(bus.out_data), 64'(0));
        check("mid_rst_out_exp", 64'(bus.out_exp), 64'(0));
        check("mid_rst_flags", 64'({bus.out_zero, bus.out_underflow}), 64'(0));
`ifdef NORM_SHIFT_STATS_EN
        check("mid_rst_op_count", 64'(op_count), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_no_output", 64'(bus.out_valid), 64'(0));
        end

        // after reset, one count per completed handshake
        for (int k = 1; k <= 3; k++) begin
            model(32'h0000_0010 << k, 8'd40, rd, re, rz, ru, rlat);
            run_op(32'h0000_0010 << k, 8'd40, 1'b1, od, oe, oz, ou, lat);
            check($sformatf("post_rst%0d_data", k), 64'(od), 64'(rd));
            check($sformatf("post_rst%0d_exp", k), 64'(oe), 64'(re));
`ifdef NORM_SHIFT_STATS_EN
            check($sformatf("op_count_%0d", k), 64'(op_count), 64'(k));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
